// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store sequencer for a byte-wide data memory.
// Splits each request into 1/2/4 little-endian byte accesses and rejects bad requests without touching memory.
module load_store_unit #(
  parameter int MEM_BYTES  = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  LsuRequest,
  input  logic                  LsuWrite,
  input  logic [2:0]            LsuFunct3,
  input  logic [ADDR_WIDTH-1:0] LsuAddress,
  input  logic [31:0]           LsuWriteData,
  output logic                  LsuBusy,
  output logic                  LsuDone,
  output logic                  LsuFault,
  output logic [31:0]           LsuReadData,
  output logic                  DmemWriteEnable,
  output logic                  DmemReadEnable,
  output logic [ADDR_WIDTH-1:0] DmemAddress,
  output logic [31:0]           DmemWriteData,
  input  logic [31:0]           DmemReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state_r;
  logic                    write_r;
  logic                    fault_r;
  logic [2:0]              funct3_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic [31:0]             wdata_r;
  logic [31:0]             asm_r;
  logic [1:0]              cnt_r;
  logic [1:0]              last_r;

  logic [2:0]              nbytes_s;
  logic [1:0]              last_s;
  logic [ADDR_WIDTH:0]     end_addr_s;
  logic                    req_fault_s;
  logic [31:0]             asm_next_s;
  logic [1:0]              cnt_inc_s;

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
    logic [31:0] res;
    case (f3)
      3'b000:  res = {{24{raw[7]}}, raw[7:0]};
      3'b001:  res = {{16{raw[15]}}, raw[15:0]};
      3'b100:  res = {24'd0, raw[7:0]};
      3'b101:  res = {16'd0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // Request decode: access size and rejection check, evaluated on the incoming request.
  always_comb begin
    nbytes_s = 3'd1;
    case (LsuFunct3[1:0])
      2'b00:   nbytes_s = 3'd1;
      2'b01:   nbytes_s = 3'd2;
      2'b10:   nbytes_s = 3'd4;
      default: nbytes_s = 3'd1;
    endcase
    last_s     = nbytes_s[1:0] - 2'd1;
    // widened by one bit so an access near the top of the address space cannot wrap past the limit
    end_addr_s = {1'b0, LsuAddress} + (ADDR_WIDTH+1)'(nbytes_s - 3'd1);
    req_fault_s = (LsuFunct3 == 3'b011) || (LsuFunct3[2:1] == 2'b11) ||
                  (LsuWrite && LsuFunct3[2]) ||
                  ((LsuFunct3[1:0] == 2'b01) && LsuAddress[0]) ||
                  ((LsuFunct3[1:0] == 2'b10) && (LsuAddress[1:0] != 2'b00)) ||
                  (end_addr_s >= (ADDR_WIDTH+1)'(MEM_BYTES));
  end

  // Load assembly: merge the byte arriving this cycle into its little-endian slot.
  always_comb begin
    asm_next_s = asm_r;
    cnt_inc_s  = cnt_r + 2'd1;
    case (cnt_r)
      2'd0:    asm_next_s[7:0]   = DmemReadData[7:0];
      2'd1:    asm_next_s[15:8]  = DmemReadData[7:0];
      2'd2:    asm_next_s[23:16] = DmemReadData[7:0];
      default: asm_next_s[31:24] = DmemReadData[7:0];
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_r         <= IDLE;
      write_r         <= 1'b0;
      fault_r         <= 1'b0;
      funct3_r        <= 3'd0;
      base_r          <= '0;
      wdata_r         <= 32'd0;
      asm_r           <= 32'd0;
      cnt_r           <= 2'd0;
      last_r          <= 2'd0;
      LsuBusy         <= 1'b0;
      LsuDone         <= 1'b0;
      LsuFault        <= 1'b0;
      LsuReadData     <= 32'd0;
      DmemWriteEnable <= 1'b0;
      DmemReadEnable  <= 1'b0;
      DmemAddress     <= '0;
      DmemWriteData   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          LsuDone  <= 1'b0;
          LsuFault <= 1'b0;
          if (LsuRequest) begin
            // a rejected request still spends one ACCESS cycle, with no strobes, so it completes like a 1-byte access
            state_r  <= ACCESS;
            LsuBusy  <= 1'b1;
            write_r  <= LsuWrite;
            funct3_r <= LsuFunct3;
            base_r   <= LsuAddress;
            wdata_r  <= LsuWriteData;
            fault_r  <= req_fault_s;
            cnt_r    <= 2'd0;
            last_r   <= last_s;
            if (!req_fault_s) begin
              DmemAddress     <= LsuAddress;
              DmemWriteEnable <= LsuWrite;
              DmemReadEnable  <= ~LsuWrite;
              DmemWriteData   <= {24'd0, LsuWriteData[7:0]};
            end
          end
        end
        ACCESS: begin
          if (fault_r) begin
            state_r  <= DONE;
            LsuDone  <= 1'b1;
            LsuFault <= 1'b1;
          end else begin
            asm_r <= asm_next_s;
            if (cnt_r == last_r) begin
              state_r         <= DONE;
              LsuDone         <= 1'b1;
              LsuFault        <= 1'b0;
              DmemWriteEnable <= 1'b0;
              DmemReadEnable  <= 1'b0;
              DmemWriteData   <= 32'd0;
              if (!write_r) begin
                LsuReadData <= extend_load(funct3_r, asm_next_s);
              end
            end else begin
              cnt_r         <= cnt_inc_s;
              DmemAddress   <= base_r + ADDR_WIDTH'(cnt_inc_s);
              DmemWriteData <= {24'd0, byte_sel(wdata_r, cnt_inc_s)};
            end
          end
        end
        DONE: begin
          state_r  <= IDLE;
          LsuBusy  <= 1'b0;
          LsuDone  <= 1'b0;
          LsuFault <= 1'b0;
        end
        default: begin
          state_r         <= IDLE;
          LsuBusy         <= 1'b0;
          LsuDone         <= 1'b0;
          LsuFault        <= 1'b0;
          DmemWriteEnable <= 1'b0;
          DmemReadEnable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-wide memory model plus a queue of expected completions.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        LsuRequest;
  logic        LsuWrite;
  logic [2:0]  LsuFunct3;
  logic [31:0] LsuAddress;
  logic [31:0] LsuWriteData;
  logic        LsuBusy;
  logic        LsuDone;
  logic        LsuFault;
  logic [31:0] LsuReadData;
  logic        DmemWriteEnable;
  logic        DmemReadEnable;
  logic [31:0] DmemAddress;
  logic [31:0] DmemWriteData;
  logic [31:0] DmemReadData;

  logic [7:0]  mem [0:127];
  logic        mem_load;

  int          total = 0;
  int          bad = 0;
  int          rd_cnt;
  int          we_cnt;
  int          both_hi = 0;
  logic [31:0] addr_seen[$];
  logic [31:0] wd_seen[$];
  logic [32:0] sb_q[$];
  logic [31:0] model_rd;

  load_store_unit #(.MEM_BYTES(128), .ADDR_WIDTH(32)) dut (
    .Clock(Clock), .ResetN(ResetN), .LsuRequest(LsuRequest), .LsuWrite(LsuWrite),
    .LsuFunct3(LsuFunct3), .LsuAddress(LsuAddress), .LsuWriteData(LsuWriteData),
    .LsuBusy(LsuBusy), .LsuDone(LsuDone), .LsuFault(LsuFault), .LsuReadData(LsuReadData),
    .DmemWriteEnable(DmemWriteEnable), .DmemReadEnable(DmemReadEnable),
    .DmemAddress(DmemAddress), .DmemWriteData(DmemWriteData), .DmemReadData(DmemReadData)
  );

  always #5 Clock = ~Clock;

  assign DmemReadData = (DmemAddress < 32'd128) ? {24'd0, mem[DmemAddress[6:0]]} : 32'd0;

  always @(posedge Clock) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'd0;
      mem[0]   <= 8'd2;
      mem[1]   <= 8'd49;
      mem[2]   <= 8'd1;
      mem[3]   <= 8'd12;
      mem[108] <= 8'h11;
      mem[109] <= 8'h22;
      mem[110] <= 8'h33;
      mem[111] <= 8'h44;
    end else if (DmemWriteEnable && (DmemAddress < 32'd128)) begin
      mem[DmemAddress[6:0]] <= DmemWriteData[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int lat);
    logic [32:0] e;
    logic        got;
    got = 1'b0;
    rd_cnt = 0;
    we_cnt = 0;
    addr_seen.delete();
    wd_seen.delete();
    for (int k = 0; k < 16; k++) begin
      if (DmemReadEnable && DmemWriteEnable) both_hi++;
      if (DmemReadEnable) begin
        rd_cnt++;
        addr_seen.push_back(DmemAddress);
      end
      if (DmemWriteEnable) begin
        we_cnt++;
        addr_seen.push_back(DmemAddress);
        wd_seen.push_back(DmemWriteData);
      end
      if (LsuDone) begin
        got = 1'b1;
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 33'h1_DEAD_DEAD;
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " fault"}, {31'd0, LsuFault}, {31'd0, e[32]});
        chk({tag, " rdata"}, LsuReadData, e[31:0]);
        chk({tag, " busy@done"}, {31'd0, LsuBusy}, 32'd1);
        chk({tag, " en@done"}, {30'd0, DmemReadEnable, DmemWriteEnable}, 32'd0);
        break;
      end
      @(posedge Clock); #1;
    end
    chk({tag, " done seen"}, {31'd0, got}, 32'd1);
    @(posedge Clock); #1;
    chk({tag, " busy after"}, {31'd0, LsuBusy}, 32'd0);
    chk({tag, " done after"}, {31'd0, LsuDone}, 32'd0);
  endtask

  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_fault,
                         input int lat, input string tag, input logic hold);
    sb_q.push_back({exp_fault, exp_rd});
    model_rd     = exp_rd;
    LsuWrite     = wr;
    LsuFunct3    = f3;
    LsuAddress   = addr;
    LsuWriteData = wdata;
    LsuRequest   = 1'b1;
    @(posedge Clock); #1;
    if (!hold) LsuRequest = 1'b0;
    wait_done(tag, lat);
  endtask

  initial begin
    ResetN = 1'b0; mem_load = 1'b1; LsuRequest = 1'b0; LsuWrite = 1'b0;
    LsuFunct3 = 3'd0; LsuAddress = 32'd0; LsuWriteData = 32'd0; model_rd = 32'd0;
    repeat (2) @(posedge Clock);
    #1;
    chk("reset busy", {31'd0, LsuBusy}, 32'd0);
    chk("reset done", {31'd0, LsuDone}, 32'd0);
    chk("reset rdata", LsuReadData, 32'd0);
    chk("reset en", {30'd0, DmemReadEnable, DmemWriteEnable}, 32'd0);
    ResetN = 1'b1; mem_load = 1'b0;
    @(posedge Clock); #1;

    run_req(1'b0, 3'b010, 32'd0, 32'd0, 32'h0C013102, 1'b0, 4, "lw0", 1'b0);
    chk("lw0 reads", 32'(rd_cnt), 32'd4);
    chk("lw0 writes", 32'(we_cnt), 32'd0);
    for (int i = 0; i < 4; i++)
      chk("lw0 addr", (i < addr_seen.size()) ? addr_seen[i] : 32'hFFFFFFFF, 32'(i));

    run_req(1'b1, 3'b000, 32'd100, 32'h000000F0, model_rd, 1'b0, 1, "sb100", 1'b0);
    chk("sb100 writes", 32'(we_cnt), 32'd1);
    chk("sb100 wdata", (wd_seen.size() > 0) ? wd_seen[0] : 32'hFFFFFFFF, 32'h000000F0);
    run_req(1'b0, 3'b000, 32'd100, 32'd0, 32'hFFFFFFF0, 1'b0, 1, "lb100", 1'b0);
    run_req(1'b0, 3'b100, 32'd100, 32'd0, 32'h000000F0, 1'b0, 1, "lbu100", 1'b0);

    run_req(1'b1, 3'b010, 32'd104, 32'hDEADBEEF, model_rd, 1'b0, 4, "sw104", 1'b0);
    chk("sw104 writes", 32'(we_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("sw104 addr", (i < addr_seen.size()) ? addr_seen[i] : 32'hFFFFFFFF, 32'(104 + i));
      chk("sw104 wdata", (i < wd_seen.size()) ? wd_seen[i] : 32'hFFFFFFFF,
          {24'd0, 8'(32'hDEADBEEF >> (8 * i))});
    end
    run_req(1'b0, 3'b010, 32'd104, 32'd0, 32'hDEADBEEF, 1'b0, 4, "lw104", 1'b0);
    run_req(1'b0, 3'b001, 32'd106, 32'd0, 32'hFFFFDEAD, 1'b0, 2, "lh106", 1'b0);
    run_req(1'b0, 3'b101, 32'd104, 32'd0, 32'h0000BEEF, 1'b0, 2, "lhu104", 1'b0);
    run_req(1'b0, 3'b000, 32'd127, 32'd0, 32'h00000000, 1'b0, 1, "lb127", 1'b0);

    run_req(1'b0, 3'b001, 32'd1, 32'd0, model_rd, 1'b1, 1, "lh1 flt", 1'b0);
    chk("lh1 flt en", 32'(rd_cnt + we_cnt), 32'd0);
    run_req(1'b0, 3'b010, 32'd126, 32'd0, model_rd, 1'b1, 1, "lw126 flt", 1'b0);
    chk("lw126 flt en", 32'(rd_cnt + we_cnt), 32'd0);
    run_req(1'b0, 3'b011, 32'd0, 32'd0, model_rd, 1'b1, 1, "f3=011 flt", 1'b0);
    chk("f3=011 flt en", 32'(rd_cnt + we_cnt), 32'd0);
    run_req(1'b1, 3'b100, 32'd0, 32'h5A5A5A5A, model_rd, 1'b1, 1, "st100 flt", 1'b0);
    chk("st100 flt en", 32'(rd_cnt + we_cnt), 32'd0);

    // request held high through a whole access; only re-accepted once back in IDLE
    run_req(1'b0, 3'b010, 32'd0, 32'd0, 32'h0C013102, 1'b0, 4, "held1", 1'b1);
    chk("held1 reads", 32'(rd_cnt), 32'd4);
    sb_q.push_back({1'b0, 32'h0C013102});
    @(posedge Clock); #1;
    LsuRequest = 1'b0;
    chk("held2 accepted", {31'd0, LsuBusy}, 32'd1);
    wait_done("held2", 4);
    chk("held2 reads", 32'(rd_cnt), 32'd4);

    // reset in the middle of the third byte of a store
    LsuWrite = 1'b1; LsuFunct3 = 3'b010; LsuAddress = 32'd108; LsuWriteData = 32'hA1B2C3D4;
    LsuRequest = 1'b1;
    @(posedge Clock); #1;
    LsuRequest = 1'b0;
    repeat (2) begin @(posedge Clock); #1; end
    chk("rst mid addr", DmemAddress, 32'd110);
    chk("rst mid we", {31'd0, DmemWriteEnable}, 32'd1);
    #2 ResetN = 1'b0;
    #1;
    chk("rst busy", {31'd0, LsuBusy}, 32'd0);
    chk("rst done", {30'd0, LsuDone, LsuFault}, 32'd0);
    chk("rst rdata", LsuReadData, 32'd0);
    chk("rst en", {30'd0, DmemReadEnable, DmemWriteEnable}, 32'd0);
    chk("rst addr", DmemAddress, 32'd0);
    chk("rst wdata", DmemWriteData, 32'd0);
    #2 ResetN = 1'b1;
    model_rd = 32'd0;
    run_req(1'b0, 3'b010, 32'd108, 32'd0, 32'h4433C3D4, 1'b0, 4, "lw108 post rst", 1'b0);

    chk("both enables", 32'(both_hi), 32'd0);
    chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
